// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: merges n_req valid/ready streams into one downstream stream.
// Ownership is granted round-robin and held for exactly `burst` transfers, so a
// multi-beat sample from one requester is never interleaved with another's.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   req_valid   per-requester valid (bit i = requester i)
//   req_ready   per-requester ready (only the owner may see down_ready)
//   req_data    requester i data at [i*width +: width]
//   down_valid  merged stream valid
//   down_ready  merged stream ready
//   down_data   merged stream data
//   grant       one-hot owner, zero when nobody owns the stream
//   busy        high while a burst is locked
module stream_rr_arbiter #(
  parameter int unsigned width = 8,
  parameter int unsigned n_req = 3,
  parameter int unsigned burst = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_data,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic [width-1:0]       down_data,
  output logic [n_req-1:0]       grant,
  output logic                   busy
);

  localparam int unsigned PtrW  = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned ScanW = PtrW + 1;
  localparam int unsigned CntW  = (burst > 1) ? $clog2(burst) : 1;

  localparam logic [CntW-1:0]  LastBeat = CntW'(burst - 1);
  localparam logic [PtrW-1:0]  LastReq  = PtrW'(n_req - 1);
  localparam logic [ScanW-1:0] NumReq   = ScanW'(n_req);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  owner_q, owner_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [n_req-1:0] grant_q, grant_d;

  logic             locked;
  logic             xfer;
  logic             pick_found;
  logic [PtrW-1:0]  pick_idx;
  logic [PtrW-1:0]  next_ptr;
  logic [ScanW-1:0] scan;

  // rst is active-low; gating with it keeps every output quiet while reset is held,
  // not only from the cycle after the reset edge.
  assign locked = (state_q == StLock) && rst;
  assign busy   = locked;
  assign grant  = locked ? grant_q : '0;
  assign xfer   = down_valid & down_ready;

  assign next_ptr = (owner_q == LastReq) ? '0 : owner_q + PtrW'(1);

  // Owner's stream is passed straight through; everyone else is held off.
  always_comb begin
    down_valid = 1'b0;
    down_data  = '0;
    req_ready  = '0;
    if (locked) begin
      down_valid = req_valid[owner_q];
      down_data  = req_data[32'(owner_q)*width +: width];
      req_ready  = grant_q & {n_req{down_ready}};
    end
  end

  // First valid requester at or above ptr, wrapping modulo n_req.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int unsigned k = 0; k < n_req; k++) begin
      scan = {1'b0, ptr_q} + ScanW'(k);
      if (scan >= NumReq) begin
        scan = scan - NumReq;
      end
      if (!pick_found && req_valid[scan[PtrW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[PtrW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StLock;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      StLock: begin
        // The lock is only released by the final beat; a stalled or silent owner keeps it.
        if (xfer) begin
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
            cnt_d   = '0;
            grant_d = '0;
            ptr_d   = next_ptr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter width, default 8: data bits per beat.
REQ-002 SHALL have parameter n_req, default 3: number of upstream requesters (X/Y/Z sensor streams); legal range 1..8.
REQ-003 SHALL have parameter burst, default 2: beats per locked grant (bytes per sample); legal range 1..16.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-006 SHALL have port req_valid  input  n_req: per-requester valid, bit i for requester i.
REQ-007 SHALL have port req_ready  output  n_req: per-requester ready.
REQ-008 SHALL have port req_data  input  n_req*width: requester i data in bits [i*width +: width].
REQ-009 SHALL have port down_valid  output  1: merged stream valid, toward the stream FIFO.
REQ-010 SHALL have port down_ready  input  1: merged stream ready, from the stream FIFO.
REQ-011 SHALL have port down_data  output  width: merged stream data.
REQ-012 SHALL have port grant  output  n_req: one-hot current owner; all zero when no owner.
REQ-013 SHALL have port busy  output  1: high while a burst is locked.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-015 In IDLE, SHALL hold grant=0, down_valid=0, req_ready=0, and ignore down_ready.
REQ-016 In IDLE with any req_valid high, SHALL pick the first requester with valid high, searching from pointer ptr upward, mod n_req; on the next edge it SHALL register grant to that requester and enter LOCK. This gives a 1-cycle arbitration latency.
REQ-017 In IDLE with no req_valid high, SHALL remain in IDLE with ptr unchanged.
REQ-018 In LOCK with owner g, these signals SHALL be combinational:
- down_valid = req_valid[g]
- down_data = req_data[g]
- req_ready[g] = down_ready
- req_ready of every other requester = 0
REQ-019 A transfer SHALL be defined as down_valid & down_ready; only transfers SHALL advance the beat counter.
REQ-020 The beat counter SHALL be max(1,$clog2(burst)) bits wide, reset to 0, and increment by 1 per transfer.
REQ-021 On a transfer with counter == burst-1, the block SHALL, on that edge:
- return to IDLE
- clear the counter to 0
- clear grant
- set ptr = (g+1) mod n_req, with wrap from n_req-1 to 0
REQ-022 If the owner drops req_valid mid-burst, SHALL hold the lock indefinitely, with no timeout and no re-arbitration, until the burst completes.
REQ-023 Back-to-back bursts SHALL incur exactly one IDLE cycle between the last beat of one burst and the first possible beat of the next.
REQ-024 Requester valids arriving or changing during LOCK SHALL not affect the owner or ptr.
REQ-025 With burst=1, every transfer SHALL end the lock; with n_req=1, ptr SHALL stay 0.
REQ-026 busy SHALL equal (state == LOCK); grant SHALL be nonzero if and only if busy.
REQ-027 Data SHALL never be reordered, duplicated or dropped within a requester's stream.

Reset
REQ-028 On a clock edge with rst=0, SHALL set state=IDLE, ptr=0, counter=0 and grant=0, which makes down_valid=0, req_ready=0 and busy=0 from the following cycle.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no completion beat; after release, arbitration SHALL restart from requester 0.
REQ-030 While rst=0, all outputs SHALL be held at their reset values regardless of inputs.

Verification
REQ-031 Bench: reset, then req_valid=3'b111 constant with data X=0x11, Y=0x22, Z=0x33 and down_ready=1 -> down_data sequence 11,11,22,22,33,33,11,... with one down_valid=0 cycle between pairs.
REQ-032 Bench: only req_valid[2]=1 after reset -> grant=3'b100 one cycle later; after 2 beats ptr wraps to 0; next grant goes again to 2.
REQ-033 Bench: owner 0 with first beat done, then req_valid[0]=0 for 5 cycles while req_valid[1]=1 -> grant stays 3'b001, down_valid=0, req_ready[1]=0; second beat then completes, then requester 1 is granted.
REQ-034 Bench: down_ready=0 for 4 cycles during LOCK -> down_data stable, counter unchanged, req_ready[g]=0; beats resume on down_ready=1.
REQ-035 Bench: rst=0 pulsed after first beat of requester 1 -> next cycle busy=0, grant=0; after release, with all valid high, grant goes to requester 0.
REQ-036 Bench: random valid/ready with parameters burst=1, n_req=1 and burst=3, n_req=4 -> the scoreboard matches per-requester order, and there is never more than one bit set in grant.
